// File: rtl/skeleton_clk_pkg.sv
// Shared types and constants for the skeleton clock/reset sequencer.
package skeleton_clk_pkg;

    // Sequencer states; encoding is visible on the debug state port.
    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        PAUSE  = 3'd1,
        RUN    = 3'd2,
        STEP   = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam int PHASES_PER_CYCLE = 4;
    localparam int PH_CORE_EDGE     = 2;

    // Phase value whose advance completes one processor cycle.
    localparam logic [1:0] PH_LAST = 2'(PHASES_PER_CYCLE - 1);

    // Phases advance only in states where the core is being clocked.
    function automatic logic phases_running(input state_t s);
        return (s == HOLD) || (s == RUN) || (s == STEP);
    endfunction

endpackage

// File: rtl/skeleton_clock_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled events, holding at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/skeleton_clock_sequencer.sv
// Derives memory/core clock phases from the board clock, sequences core
// reset, and provides run / pause / single-step / halt control.
module skeleton_clock_sequencer
    import skeleton_clk_pkg::*;
#(
    parameter int RESET_HOLD = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_en,
    input  logic             step_req,
    input  logic             halt,
    output logic             imem_clock,
    output logic             dmem_clock,
    output logic             processor_clock,
    output logic             regfile_clock,
    output logic             core_reset,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       state,
    output logic             done
);

    // Wide enough to hold RESET_HOLD-1; the counter stops there.
    localparam int HOLD_W = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD);

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        ph_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              running;
    logic              cyc_done;
    logic              hold_last;
    logic              core_reset_q;
    logic              done_q;

    assign running   = phases_running(state_q);
    assign cyc_done  = running && (ph_q == PH_LAST);
    assign hold_last = (hold_cnt == HOLD_W'(RESET_HOLD - 1));

    // Completed cycles spent in HOLD; cleared whenever HOLD is left.
    sat_counter #(.W(HOLD_W)) u_hold_cnt (
        .clock (clock),
        .reset (reset),
        .clear (state_q != HOLD),
        .en    (cyc_done && (state_q == HOLD) && !hold_last),
        .count (hold_cnt)
    );

    // Retired processor cycles; HOLD cycles are not counted.
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .en    (cyc_done && ((state_q == RUN) || (state_q == STEP))),
        .count (cycle_count)
    );

    // Next-state decode; RUN/STEP/HOLD only move at cycle completion so the
    // core never sees a partial processor cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HOLD: begin
                if (cyc_done && hold_last) begin
                    state_d = run_en ? RUN : PAUSE;
                end
            end
            PAUSE: begin
                if (run_en) begin
                    state_d = RUN;
                end else if (step_req) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (cyc_done) begin
                    if (halt) begin
                        state_d = HALTED;
                    end else if (!run_en) begin
                        state_d = PAUSE;
                    end
                end
            end
            STEP: begin
                if (cyc_done) begin
                    state_d = halt ? HALTED : PAUSE;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = HOLD;
        endcase
    end

    // State, phase and registered status flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= HOLD;
            ph_q         <= 2'd0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= running ? (ph_q + 2'd1) : 2'd0;
            core_reset_q <= (state_d == HOLD);
            done_q       <= (state_d == HALTED);
        end
    end

    // Memory edges bracket the core edge (ph 1->2) on 0->1 and 2->3.
    assign imem_clock      = ph_q[0];
    assign dmem_clock      = ph_q[0];
    assign processor_clock = ph_q[1];
    assign regfile_clock   = ph_q[1];
    assign core_reset      = core_reset_q;
    assign done            = done_q;
    assign state           = state_q;

endmodule

// File: tb/tb_skeleton_clock_sequencer.sv
// Directed bench for skeleton_clock_sequencer.
module tb_skeleton_clock_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run_en = 1'b0;
    logic        step_req = 1'b0;
    logic        halt = 1'b0;
    logic        imem_clock, dmem_clock, processor_clock, regfile_clock;
    logic        core_reset, done;
    logic [31:0] cycle_count;
    logic [2:0]  state;
    logic        s_imem, s_dmem, s_proc, s_reg, s_core_reset, s_done;
    logic [2:0]  s_count;
    logic [2:0]  s_state;

    int errors = 0;
    int checks = 0;

    // Clock generation.
    always #5 clock = ~clock;

    skeleton_clock_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .run_en          (run_en),
        .step_req        (step_req),
        .halt            (halt),
        .imem_clock      (imem_clock),
        .dmem_clock      (dmem_clock),
        .processor_clock (processor_clock),
        .regfile_clock   (regfile_clock),
        .core_reset      (core_reset),
        .cycle_count     (cycle_count),
        .state           (state),
        .done            (done)
    );

    skeleton_clock_sequencer #(.CNT_W(3)) dut_small (
        .clock           (clock),
        .reset           (reset),
        .run_en          (run_en),
        .step_req        (step_req),
        .halt            (halt),
        .imem_clock      (s_imem),
        .dmem_clock      (s_dmem),
        .processor_clock (s_proc),
        .regfile_clock   (s_reg),
        .core_reset      (s_core_reset),
        .cycle_count     (s_count),
        .state           (s_state),
        .done            (s_done)
    );

    // Advance one board clock and sample just after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Release reset and count edges until core_reset drops (bounded).
    task automatic wait_release(output int n);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (!core_reset) break;
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0; run_en = 1'b1;
        tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset got=%b exp=1", core_reset); end
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cycle_count); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if ({imem_clock, dmem_clock, processor_clock, regfile_clock} !== 4'b0000) begin
            errors++; $display("FAIL reset_clocks got=%b exp=0000", {imem_clock, dmem_clock, processor_clock, regfile_clock});
        end
        wait_release(n);
        checks++; if (n !== 16) begin errors++; $display("FAIL reset_hold_len got=%0d exp=16", n); end
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL release_state got=%0d exp=2", state); end
        tick();
        checks++; if (processor_clock !== 1'b0 || imem_clock !== 1'b1) begin
            errors++; $display("FAIL release_ph1 got proc=%b imem=%b exp proc=0 imem=1", processor_clock, imem_clock);
        end
        tick();
        checks++; if (processor_clock !== 1'b1 || regfile_clock !== 1'b1) begin
            errors++; $display("FAIL first_core_edge got proc=%b reg=%b exp 1 1", processor_clock, regfile_clock);
        end
        tick(18);
        checks++; if (cycle_count !== 32'd5) begin errors++; $display("FAIL run_count got=%0d exp=5", cycle_count); end
    endtask

    task automatic test_step();
        int n;
        int rises;
        logic prev;
        reset = 1'b0; run_en = 1'b0;
        tick();
        wait_release(n);
        checks++; if (n !== 16 || state !== 3'd1) begin
            errors++; $display("FAIL step_pause_entry got n=%0d state=%0d exp n=16 state=1", n, state);
        end
        rises = 0;
        for (int k = 0; k < 3; k++) begin
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            checks++; if (state !== 3'd3) begin errors++; $display("FAIL step_enter_%0d got=%0d exp=3", k, state); end
            prev = processor_clock;
            for (int j = 1; j <= 5; j++) begin
                tick();
                if (processor_clock && !prev) rises++;
                prev = processor_clock;
                if (j == 2) begin
                    checks++; if (processor_clock !== 1'b1) begin errors++; $display("FAIL step_core_edge_%0d got=%b exp=1", k, processor_clock); end
                end
                if (j == 4) begin
                    checks++; if (state !== 3'd1) begin errors++; $display("FAIL step_return_%0d got=%0d exp=1", k, state); end
                end
            end
        end
        checks++; if (rises !== 3) begin errors++; $display("FAIL step_rises got=%0d exp=3", rises); end
        checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL step_count got=%0d exp=3", cycle_count); end
    endtask

    task automatic test_pause_mid();
        int rises;
        logic prev;
        run_en = 1'b1; step_req = 1'b1;
        tick();
        step_req = 1'b0;
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL run_beats_step got=%0d exp=2", state); end
        tick();
        checks++; if (imem_clock !== 1'b1 || processor_clock !== 1'b0) begin
            errors++; $display("FAIL pause_mid_ph1 got imem=%b proc=%b exp 1 0", imem_clock, processor_clock);
        end
        run_en = 1'b0;
        rises = 0;
        prev = processor_clock;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (processor_clock && !prev) rises++;
            prev = processor_clock;
        end
        checks++; if (rises !== 1) begin errors++; $display("FAIL pause_mid_edge got=%0d exp=1", rises); end
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL pause_mid_state got=%0d exp=1", state); end
        checks++; if (cycle_count !== 32'd4) begin errors++; $display("FAIL pause_mid_count got=%0d exp=4", cycle_count); end
        tick(2);
        checks++; if ({imem_clock, dmem_clock, processor_clock, regfile_clock} !== 4'b0000 || state !== 3'd1) begin
            errors++; $display("FAIL pause_frozen got clocks=%b state=%0d exp 0000 1",
                {imem_clock, dmem_clock, processor_clock, regfile_clock}, state);
        end
    endtask

    task automatic test_halt();
        run_en = 1'b1;
        tick();
        tick(3);
        checks++; if (imem_clock !== 1'b1 || processor_clock !== 1'b1) begin
            errors++; $display("FAIL halt_ph3 got imem=%b proc=%b exp 1 1", imem_clock, processor_clock);
        end
        halt = 1'b1; run_en = 1'b0;
        tick();
        halt = 1'b0;
        checks++; if (state !== 3'd4 || done !== 1'b1) begin
            errors++; $display("FAIL halt_enter got state=%0d done=%b exp 4 1", state, done);
        end
        checks++; if (cycle_count !== 32'd5) begin errors++; $display("FAIL halt_count got=%0d exp=5", cycle_count); end
        step_req = 1'b1;
        tick();
        step_req = 1'b0; run_en = 1'b1;
        tick(8);
        checks++; if (state !== 3'd4 || done !== 1'b1 || cycle_count !== 32'd5) begin
            errors++; $display("FAIL halt_sticky got state=%0d done=%b count=%0d exp 4 1 5", state, done, cycle_count);
        end
        checks++; if ({imem_clock, processor_clock} !== 2'b00) begin
            errors++; $display("FAIL halt_clocks got=%b exp=00", {imem_clock, processor_clock});
        end
    endtask

    task automatic test_reset_mid();
        int n;
        reset = 1'b0; run_en = 1'b1;
        tick();
        wait_release(n);
        checks++; if (n !== 16) begin errors++; $display("FAIL mid_release got=%0d exp=16", n); end
        tick(30);
        checks++; if (cycle_count !== 32'd7 || processor_clock !== 1'b1 || imem_clock !== 1'b0) begin
            errors++; $display("FAIL mid_setup got count=%0d proc=%b imem=%b exp 7 1 0", cycle_count, processor_clock, imem_clock);
        end
        reset = 1'b0;
        tick();
        checks++; if (cycle_count !== 32'd0 || core_reset !== 1'b1 || state !== 3'd0) begin
            errors++; $display("FAIL mid_abort got count=%0d core_reset=%b state=%0d exp 0 1 0", cycle_count, core_reset, state);
        end
        checks++; if ({imem_clock, dmem_clock, processor_clock, regfile_clock, done} !== 5'b00000) begin
            errors++; $display("FAIL mid_abort_clocks got=%b exp=00000", {imem_clock, dmem_clock, processor_clock, regfile_clock, done});
        end
    endtask

    task automatic test_saturate();
        int n;
        run_en = 1'b1;
        wait_release(n);
        tick(40);
        checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL sat_wide got=%0d exp=10", cycle_count); end
        checks++; if (s_count !== 3'd7) begin errors++; $display("FAIL sat_narrow got=%0d exp=7", s_count); end
        tick(8);
        checks++; if (s_count !== 3'd7 || s_state !== 3'd2) begin
            errors++; $display("FAIL sat_hold got count=%0d state=%0d exp 7 2", s_count, s_state);
        end
    endtask

    // Scenario sequence and final report.
    initial begin
        test_reset();
        test_step();
        test_pause_mid();
        test_halt();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/skeleton_clock_sequencer.md
# skeleton_clock_sequencer

Clock-phase and reset sequencer that sits directly upstream of the skeleton processor top. It derives the `imem_clock`, `dmem_clock`, `processor_clock` and `regfile_clock` phases from the board `clock`, and holds the core in reset for a fixed number of processor cycles. It also supports run, pause, single-step and halt control, and counts retired processor cycles for the bench and debug logic.

## Interface
Parameters:
- `RESET_HOLD`, default 4: processor cycles during which `core_reset` stays asserted after `reset` releases. Minimum 1.
- `CNT_W`, default 32: width of `cycle_count`.

Ports:
- `clock`  in  1: board clock. Only clock domain.
- `reset`  in  1: synchronous, active-low reset.
- `run_en`  in  1: level. Free-run the core while high.
- `step_req`  in  1: one-clock pulse. Requests exactly one processor cycle while paused.
- `halt`  in  1: from core halt decode. Sampled once per processor cycle.
- `imem_clock`  out  1: instruction memory clock phase.
- `dmem_clock`  out  1: data memory clock phase, identical to `imem_clock`.
- `processor_clock`  out  1: core clock (clock/4).
- `regfile_clock`  out  1: register file clock, identical to `processor_clock`.
- `core_reset`  out  1: active-high reset to the skeleton.
- `cycle_count`  out  `CNT_W`: completed processor cycles since `core_reset` released.
- `state`  out  3: current FSM state, for debug.
- `done`  out  1: high while in HALTED.

## Operation
- A 2-bit phase register `ph` advances 0→1→2→3→0 only in the HOLD, RUN and STEP states. In all other states it is frozen at 0.
- Phase outputs:
  - `imem_clock = dmem_clock = ph[0]`
  - `processor_clock = regfile_clock = ph[1]`
  - Core rising edge occurs on the ph 1→2 transition.
  - Memory rising edges occur on 0→1 and 2→3, i.e. before and after the core edge.
- One processor cycle is one full pass of ph 0..3. A cycle completes when ph==3 advances to 0.
- FSM states: HOLD, PAUSE, RUN, STEP, HALTED.
  - HOLD: `core_reset`=1. Phases run so the core sees clock edges during reset. After `RESET_HOLD` completed cycles, go to RUN if `run_en`=1, else PAUSE. `core_reset` drops on the same edge.
  - PAUSE: clocks frozen low.
    - `run_en`=1 → RUN. If `step_req` arrives in the same clock, `run_en` wins.
    - `step_req`=1 → STEP.
  - RUN: at cycle completion, evaluate in priority order:
    - `halt`=1 → HALTED.
    - else `run_en`=0 → PAUSE.
    - else stay in RUN.
  - STEP: at cycle completion, `halt`=1 → HALTED, else → PAUSE.
  - HALTED: clocks frozen low, `done`=1. The only exit is `reset`.
- `step_req` is ignored outside PAUSE. `run_en` is only evaluated at cycle boundaries, so a partial processor cycle never occurs.
- `cycle_count` increments on each completed cycle in RUN or STEP. It saturates at all-ones and does not wrap. It does not count during HOLD.

## Timing
- `reset`=0 sampled at a rising edge. On the next edge:
  - state HOLD, ph=0, all clock outputs 0
  - `core_reset`=1, `cycle_count`=0, `done`=0
- `reset` asserted mid-cycle aborts immediately to the values above, regardless of state.
- `core_reset` deasserts exactly 4·`RESET_HOLD` clocks after the first edge with `reset`=1 sampled (16 clocks by default).
- A step request sampled in PAUSE:
  - STEP is entered on the next edge.
  - The core rising edge follows 2 clocks later.
  - Return to PAUSE happens 4 clocks after entering STEP.
- All outputs are registered or single-bit taps of registers. No combinational path from inputs to outputs.

## Structure
- Package `skeleton_clk_pkg`:
  - state enum (HOLD=0, PAUSE=1, RUN=2, STEP=3, HALTED=4)
  - `PHASES_PER_CYCLE`=4
  - `PH_CORE_EDGE`=2
- One natural sub-module: `sat_counter`, parameterised width, with clear, enable and saturate. It is used for `cycle_count` and the HOLD cycle counter.

## Test plan
- Reset with `run_en`=1, `RESET_HOLD`=4 → `core_reset` high for 16 clocks. First `processor_clock` rise 2 clocks after release. `cycle_count`=5 after 20 more clocks.
- `run_en`=0 after reset, pulse `step_req` 3 times, spaced 6 clocks apart → exactly 3 `processor_clock` rises, `cycle_count`=3, state returns to PAUSE each time.
- RUN, drop `run_en` at ph=1 → current cycle completes (core edge still occurs), then PAUSE with all clocks low and `cycle_count` incremented once.
- RUN, assert `halt` and drop `run_en` in the same ph=3 clock → HALTED with `done`=1. Subsequent `step_req` and `run_en` have no effect.
- Assert `reset` low at ph=2 in RUN with `cycle_count`=7 → next edge: `cycle_count`=0, `core_reset`=1, clocks 0, state HOLD.
- `CNT_W`=3, run 10 cycles → `cycle_count` holds at 7.
